// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART receive and transmit blocks.
package uart_pkg;

  localparam int OS_RATE    = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  // Receiver FSM state encoding.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  // Even-parity bit for a data byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversampling tick generator. A down-counter reloads with DIV at
// terminal count and emits a one-cycle tick there. While clear is high the counter
// is held at zero and no tick is produced, so the first tick after clear drops
// arrives in the very first cycle.
module uart_os_tick #(
  parameter int DIV = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] cnt;

  // Down-counter with reload at terminal count, held at zero while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= CW'(DIV);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 16x oversampled, LSB-first, one-cycle rx_valid strobe.
// Build option: define UART_RX_PARITY_EN for 8E1 frames; this adds a PARITY state
// and a parity_err output. Without it the receiver handles 8N1 frames.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | validating start bit at its mid-sample
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the even-parity bit (parity builds only)
// STOP   | sampling the stop bit; byte accepted or framing error
// BREAK  | line held low after a framing error, wait for idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * OS_RATE) - 1;

  logic       rx_meta;
  logic       rx_s;
  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       os_clear;
  logic       os_tick;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       mid_smp;
  logic       bit_end;
  logic       valid_nxt;
  logic       ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic       par_bit;
  logic       perr_nxt;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign os_clear = (state == IDLE);

  uart_os_tick #(
    .DIV(OS_DIV)
  ) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(os_clear),
    .tick (os_tick)
  );

  assign mid_smp = os_tick && (os_cnt == 4'(MID_SAMPLE));
  assign bit_end = os_tick && (os_cnt == 4'(OS_RATE - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; STOP leaves at the mid-sample so back-to-back frames are caught.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (mid_smp && rx_s) state_nxt = IDLE;
        else if (bit_end)    state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == 3'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (mid_smp) state_nxt = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode at the stop-bit mid-sample; registered below.
  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt  = 1'b0;
    if (state == STOP && mid_smp) begin
      perr_nxt  = (even_parity(shift_reg) != par_bit);
      valid_nxt = rx_s && !perr_nxt;
      ferr_nxt  = !rx_s;
    end
`else
    if (state == STOP && mid_smp) begin
      valid_nxt = rx_s;
      ferr_nxt  = !rx_s;
    end
`endif
  end

  // Oversample/bit counters and the shift register; counters park at zero in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
      end else begin
        if (os_tick) os_cnt <= os_cnt + 4'd1;
        if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == DATA && mid_smp) shift_reg <= {rx_s, shift_reg[7:1]};
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && mid_smp) par_bit <= rx_s;
`endif
    end
  end

  // Registered strobes and the held output byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid   <= valid_nxt;
      frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_nxt;
`endif
      if (valid_nxt) rx_data <= shift_reg;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx (16 clocks per bit).
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BITCLK   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam longint LAT_MIN = (FRAME_BITS - 1) * BITCLK + 6;
  localparam longint LAT_MAX = (FRAME_BITS - 1) * BITCLK + 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  longint     cyc = 0;
  logic [7:0] got_q[$];
  longint     got_t[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         perr_cnt = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every strobe with its cycle stamp.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_t.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BITCLK) @(negedge clk);
  endtask

  // Serializes one frame from the line's point of view: start, data LSB first,
  // optional even parity (optionally corrupted), stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip,
                            output longint t0);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    send_bit(stop_val);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (rx_data !== 8'h00) begin $display("FAIL reset_data: got %h want 00", rx_data); n_bad++; end
    n_cmp++;
    if (rx_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", rx_valid); n_bad++; end
    n_cmp++;
    if (rx_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", rx_busy); n_bad++; end
    n_cmp++;
    if (frame_err !== 1'b0) begin $display("FAIL reset_ferr: got %b want 0", frame_err); n_bad++; end
    n_cmp++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(1);
    last_good = 8'h00;
  endtask

  task automatic test_single();
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    longint t0;
    longint lat;
    send_frame(8'h55, 1'b1, 1'b0, t0);
    idle_bits(2);
    if (got_q.size() - n0 !== 1) begin
      $display("FAIL single_count: got %0d want 1", got_q.size() - n0); n_bad++;
    end
    n_cmp++;
    if (got_q.size() > n0) begin
      if (got_q[n0] !== 8'h55) begin $display("FAIL single_data: got %h want 55", got_q[n0]); n_bad++; end
      n_cmp++;
      lat = got_t[n0] - t0;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
        $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); n_bad++;
      end
      n_cmp++;
    end
    if (ferr_cnt - f0 !== 0) begin $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); n_bad++; end
    n_cmp++;
    if (rx_busy !== 1'b0) begin $display("FAIL single_busy: got %b want 0", rx_busy); n_bad++; end
    n_cmp++;
    if (rx_data !== 8'h55) begin $display("FAIL single_hold: got %h want 55", rx_data); n_bad++; end
    n_cmp++;
    last_good = 8'h55;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int n0 = got_q.size();
    longint t0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0, t0);
      idle_bits($urandom_range(0, 3));
    end
    idle_bits(2);
    if (got_q.size() - n0 !== exp_q.size()) begin
      $display("FAIL random_count: got %0d want %0d", got_q.size() - n0, exp_q.size()); n_bad++;
    end
    n_cmp++;
    for (int k = 0; k < exp_q.size() && (n0 + k) < got_q.size(); k++) begin
      if (got_q[n0 + k] !== exp_q[k]) begin
        $display("FAIL random_data[%0d]: got %h want %h", k, got_q[n0 + k], exp_q[k]); n_bad++;
      end
      n_cmp++;
    end
    last_good = exp_q[exp_q.size() - 1];
  endtask

  task automatic test_back_to_back();
    int n0 = got_q.size();
    longint t0;
    longint t1;
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    send_frame(8'h3C, 1'b1, 1'b0, t1);
    idle_bits(2);
    if (got_q.size() - n0 !== 2) begin
      $display("FAIL b2b_count: got %0d want 2", got_q.size() - n0); n_bad++;
    end
    n_cmp++;
    if (got_q.size() >= n0 + 2) begin
      if (got_q[n0] !== 8'hA5) begin $display("FAIL b2b_first: got %h want a5", got_q[n0]); n_bad++; end
      n_cmp++;
      if (got_q[n0 + 1] !== 8'h3C) begin $display("FAIL b2b_second: got %h want 3c", got_q[n0 + 1]); n_bad++; end
      n_cmp++;
      if (got_t[n0 + 1] - got_t[n0] !== longint'(FRAME_BITS * BITCLK)) begin
        $display("FAIL b2b_spacing: got %0d want %0d", got_t[n0 + 1] - got_t[n0], FRAME_BITS * BITCLK);
        n_bad++;
      end
      n_cmp++;
    end
    last_good = 8'h3C;
  endtask

  task automatic test_glitch();
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    if (rx_busy !== 1'b1) begin $display("FAIL glitch_busy_start: got %b want 1", rx_busy); n_bad++; end
    n_cmp++;
    repeat (10) @(negedge clk);
    if (rx_busy !== 1'b0) begin $display("FAIL glitch_busy_end: got %b want 0", rx_busy); n_bad++; end
    n_cmp++;
    idle_bits(2);
    if (got_q.size() - n0 !== 0) begin $display("FAIL glitch_valid: got %0d want 0", got_q.size() - n0); n_bad++; end
    n_cmp++;
    if (ferr_cnt - f0 !== 0) begin $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); n_bad++; end
    n_cmp++;
    if (rx_data !== last_good) begin $display("FAIL glitch_hold: got %h want %h", rx_data, last_good); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_frame_err();
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    int b0 = both_cnt;
    longint t0;
    send_frame(8'hFF, 1'b0, 1'b0, t0);
    rx = 1'b0;
    repeat (30 * BITCLK) @(negedge clk);
    idle_bits(2);
    if (ferr_cnt - f0 !== 1) begin $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); n_bad++; end
    n_cmp++;
    if (got_q.size() - n0 !== 0) begin $display("FAIL ferr_valid: got %0d want 0", got_q.size() - n0); n_bad++; end
    n_cmp++;
    if (both_cnt - b0 !== 0) begin $display("FAIL ferr_overlap: got %0d want 0", both_cnt - b0); n_bad++; end
    n_cmp++;
    if (rx_data !== last_good) begin $display("FAIL ferr_hold: got %h want %h", rx_data, last_good); n_bad++; end
    n_cmp++;
    if (rx_busy !== 1'b0) begin $display("FAIL ferr_busy: got %b want 0", rx_busy); n_bad++; end
    n_cmp++;
    send_frame(8'h12, 1'b1, 1'b0, t0);
    idle_bits(2);
    if (got_q.size() - n0 !== 1) begin
      $display("FAIL ferr_recover_count: got %0d want 1", got_q.size() - n0); n_bad++;
    end else if (got_q[n0] !== 8'h12) begin
      $display("FAIL ferr_recover_data: got %h want 12", got_q[n0]); n_bad++;
    end
    n_cmp++;
    last_good = 8'h12;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h81;
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    longint t0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (BITCLK / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    if (rx_busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", rx_busy); n_bad++; end
    n_cmp++;
    if (rx_data !== 8'h00) begin $display("FAIL rstmid_data: got %h want 00", rx_data); n_bad++; end
    n_cmp++;
    if (rx_valid !== 1'b0) begin $display("FAIL rstmid_valid: got %b want 0", rx_valid); n_bad++; end
    n_cmp++;
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle_bits(2);
    if (got_q.size() - n0 !== 0 || ferr_cnt - f0 !== 0) begin
      $display("FAIL rstmid_strobes: got valid %0d ferr %0d want 0 0", got_q.size() - n0, ferr_cnt - f0);
      n_bad++;
    end
    n_cmp++;
    send_frame(8'h7E, 1'b1, 1'b0, t0);
    idle_bits(2);
    if (got_q.size() - n0 !== 1) begin
      $display("FAIL rstmid_next_count: got %0d want 1", got_q.size() - n0); n_bad++;
    end else if (got_q[n0] !== 8'h7E) begin
      $display("FAIL rstmid_next_data: got %h want 7e", got_q[n0]); n_bad++;
    end
    n_cmp++;
    last_good = 8'h7E;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n0 = got_q.size();
    int p0 = perr_cnt;
    longint t0;
    send_frame(8'h03, 1'b1, 1'b0, t0);
    idle_bits(2);
    if (got_q.size() - n0 !== 1) begin
      $display("FAIL par_good_count: got %0d want 1", got_q.size() - n0); n_bad++;
    end else if (got_q[n0] !== 8'h03) begin
      $display("FAIL par_good_data: got %h want 03", got_q[n0]); n_bad++;
    end
    n_cmp++;
    if (perr_cnt - p0 !== 0) begin $display("FAIL par_good_perr: got %0d want 0", perr_cnt - p0); n_bad++; end
    n_cmp++;
    send_frame(8'h03, 1'b1, 1'b1, t0);
    idle_bits(2);
    if (perr_cnt - p0 !== 1) begin $display("FAIL par_bad_perr: got %0d want 1", perr_cnt - p0); n_bad++; end
    n_cmp++;
    if (got_q.size() - n0 !== 1) begin
      $display("FAIL par_bad_valid: got %0d want 1", got_q.size() - n0); n_bad++;
    end
    n_cmp++;
    last_good = 8'h03;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
